// File: rtl/regfile_write_buffer.sv
// Register file write buffer: queues write requests, drains one per cycle (min latency 1, no cut-through),
// forwards pending data to the two read ports; in_ready drops only when all DEPTH entries are occupied.
module regfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       drain_en,
  output logic [ADDR_W-1:0]          DstReg,
  output logic [DATA_W-1:0]          DstData,
  output logic                       WriteReg,
  input  logic [ADDR_W-1:0]          SrcReg1,
  input  logic [ADDR_W-1:0]          SrcReg2,
  output logic                       byp_hit1,
  output logic [DATA_W-1:0]          byp_data1,
  output logic                       byp_hit2,
  output logic [DATA_W-1:0]          byp_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] dat;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  idx;
  logic              accept;
  logic              store;
  logic              not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = !rst && (count != FULL);
  assign accept    = in_valid && in_ready;
  // Register 0 is hardwired to zero, so its writes are swallowed without taking a slot.
  assign store     = accept && (in_reg != '0);
  assign WriteReg  = drain_en && not_empty;
  assign DstReg    = not_empty ? mem[head].dst : '0;
  assign DstData   = not_empty ? mem[head].dat : '0;

  // Walk from oldest to youngest so the last match wins; the head entry counts even while draining.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    idx       = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if ((SrcReg1 != '0) && (mem[idx].dst == SrcReg1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = mem[idx].dat;
        end
        if ((SrcReg2 != '0) && (mem[idx].dst == SrcReg2)) begin
          byp_hit2  = 1'b1;
          byp_data2 = mem[idx].dat;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (store)
        tail <= tail + PTR_W'(1);
      if (WriteReg)
        head <= head + PTR_W'(1);
      case ({store, WriteReg})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store)
      mem[tail] <= '{dst: in_reg, dat: in_data};
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed plus randomized bench for regfile_write_buffer against a queue-based reference model.
module tb_regfile_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_en = 1'b0;
  logic [ADDR_W-1:0] DstReg;
  logic [DATA_W-1:0] DstData;
  logic              WriteReg;
  logic [ADDR_W-1:0] SrcReg1 = '0;
  logic [ADDR_W-1:0] SrcReg2 = '0;
  logic              byp_hit1;
  logic [DATA_W-1:0] byp_data1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data2;
  logic [2:0]        count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  regfile_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .DstReg(DstReg), .DstData(DstData), .WriteReg(WriteReg),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to register s, as the read port should see it.
  task automatic model_byp(input logic [ADDR_W-1:0] s, output logic hit, output logic [DATA_W-1:0] dat);
    hit = 1'b0;
    dat = '0;
    if (s != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].r == s) begin
          hit = 1'b1;
          dat = q[i].d;
          break;
        end
      end
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then advance the model at posedge.
  task automatic cyc(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                     input logic de, input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2);
    logic e_rdy, e_wr, h1, h2;
    logic [DATA_W-1:0] d1, d2;
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d; drain_en = de; SrcReg1 = s1; SrcReg2 = s2;
    #1;
    e_rdy = (q.size() != DEPTH);
    e_wr  = de && (q.size() != 0);
    model_byp(s1, h1, d1);
    model_byp(s2, h2, d2);
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("count", 32'(count), 32'(q.size()));
    chk("WriteReg", 32'(WriteReg), 32'(e_wr));
    chk("DstReg", 32'(DstReg), (q.size() != 0) ? 32'(q[0].r) : 32'd0);
    chk("DstData", 32'(DstData), (q.size() != 0) ? 32'(q[0].d) : 32'd0);
    chk("byp_hit1", 32'(byp_hit1), 32'(h1));
    chk("byp_data1", 32'(byp_data1), 32'(d1));
    chk("byp_hit2", 32'(byp_hit2), 32'(h2));
    chk("byp_data2", 32'(byp_data2), 32'(d2));
    @(posedge clk);
    if (e_wr) void'(q.pop_front());
    if (v && e_rdy && (r != 0)) q.push_back('{r: r, d: d});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_WriteReg"}, 32'(WriteReg), 32'd0);
    chk({tag, "_DstReg"}, 32'(DstReg), 32'd0);
    chk({tag, "_DstData"}, 32'(DstData), 32'd0);
    chk({tag, "_byp_hit1"}, 32'(byp_hit1), 32'd0);
    chk({tag, "_byp_data1"}, 32'(byp_data1), 32'd0);
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    rst = 1'b0;
    cyc(0, 0, 0, 1, 3, 0);

    // Single write, drained the cycle after acceptance
    cyc(1, 3, 16'h1234, 1, 3, 0);
    cyc(0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 1, 3, 0);

    // Fill to full with drain blocked, hold a fifth request, then release the drain
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 16'(16'h0100 + i), 0, 4'(i), 2);
    cyc(1, 9, 16'h0999, 0, 9, 4);
    cyc(1, 9, 16'h0999, 0, 1, 4);
    for (int i = 0; i < 6; i++) cyc(1, 9, 16'h0999, 1, 9, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 9, 0);

    // Youngest-match bypass, miss, and zero-register read
    cyc(1, 5, 16'h0011, 0, 5, 6);
    cyc(1, 5, 16'h0022, 0, 5, 6);
    cyc(0, 0, 0, 0, 5, 6);
    cyc(0, 0, 0, 0, 0, 5);

    // Register 0 write is swallowed
    cyc(1, 0, 16'hFFFF, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 0);

    // Concurrent accept and drain at count 2 across several pointer wraps
    for (int i = 0; i < 7; i++) cyc(1, 4'(10 + (i % 5)), 16'(16'hA000 + i), 1, 4'(10 + (i % 5)), 5);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 12, 14);

    // Reset with three entries pending: nothing may drain afterwards
    for (int i = 0; i < 3; i++) cyc(1, 4'(6 + i), 16'(16'hB000 + i), 0, 7, 8);
    @(negedge clk);
    in_valid = 1'b0; drain_en = 1'b1; SrcReg1 = 7; SrcReg2 = 8;
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 7, 8);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
          1'($urandom_range(0, 99) < 45), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 3, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
